multi_level_thresh: RTL and testbench



---
 rtl/multi_level_thresh.sv | 228 ++++++++++++++++++++++
 tb/tb_multi_level_thresh.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_level_thresh.sv
// Multi-level gray thresholding: quantises a gray pixel to NUM_THRESH+1 fixed levels, optionally ramping linearly across each threshold.
// Latency: fixed 3 cycles from iValid to oValid; one pixel accepted every cycle.
// Backpressure: none; the pipeline never stalls, and gaps in iValid appear as gaps in oValid.
// Ports: iGray/iValid/iX_Cont/iY_Cont/iSmooth carry the pixel in; iThreshWr/iThreshAddr/iThreshData write the shadow
//        threshold table; oPixel/oBand/oX_Cont/oY_Cont hold the result and oValid qualifies it.
module multi_level_thresh #(
    parameter int DATA_W     = 8,
    parameter int NUM_THRESH = 2,
    parameter int RAMP_SH    = 3
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic [DATA_W-1:0]        iGray,
    input  logic                     iValid,
    input  logic signed [15:0]       iX_Cont,
    input  logic signed [15:0]       iY_Cont,
    input  logic                     iSmooth,
    input  logic                     iThreshWr,
    input  logic [2:0]               iThreshAddr,
    input  logic [DATA_W-1:0]        iThreshData,
    output logic [DATA_W-1:0]        oPixel,
    output logic                     oValid,
    output logic signed [15:0]       oX_Cont,
    output logic signed [15:0]       oY_Cont,
    output logic [2:0]               oBand
);

    localparam int NT   = NUM_THRESH;
    localparam int SW   = DATA_W + 2;
    localparam int HALF = 1 << (RAMP_SH - 1);
    localparam int PW   = DATA_W + RAMP_SH;

    localparam logic signed [SW-1:0] ZERO_S = '0;
    localparam logic signed [SW-1:0] HALF_S = SW'(HALF);
    localparam logic signed [SW-1:0] RAMP_S = SW'(2 * HALF);

    // Output level k, an elaboration constant for any constant k.
    function automatic logic [DATA_W-1:0] level_of(input int k);
        return DATA_W'((k * ((1 << DATA_W) - 1)) / NT);
    endfunction

    // Threshold j loaded into both tables at reset.
    function automatic logic [DATA_W-1:0] thresh_init_of(input int j);
        return DATA_W'((j * (1 << DATA_W)) / (NT + 1));
    endfunction

    // ------------------------------------------------------------------
    // Threshold tables
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] shadow_t [NT];
    logic [DATA_W-1:0] active_t [NT];
    logic [DATA_W-1:0] cmp_t    [NT];
    logic              commit;

    assign commit = iValid && (iX_Cont == 16'sd0) && (iY_Cont == 16'sd0);

    // Commit copies the shadow contents from before this edge, so a write
    // on the same edge lands in shadow only and waits for the next frame.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int a = 0; a < NT; a++) begin
                shadow_t[a] <= thresh_init_of(a + 1);
                active_t[a] <= thresh_init_of(a + 1);
            end
        end else begin
            for (int a = 0; a < NT; a++) begin
                if (commit) begin
                    active_t[a] <= shadow_t[a];
                end
                // Addresses >= NT match no entry and are dropped.
                if (iThreshWr && (iThreshAddr == 3'(a))) begin
                    shadow_t[a] <= iThreshData;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: compare against the table in force for this pixel
    // ------------------------------------------------------------------
    logic signed [SW-1:0] diff_c [NT];
    logic [RAMP_SH-1:0]   off_c  [NT];
    logic [NT-1:0]        ge_c;
    logic [NT-1:0]        rgn_c;

    always_comb begin
        ge_c  = '0;
        rgn_c = '0;
        for (int a = 0; a < NT; a++) begin
            // The frame-start pixel already sees the table it commits.
            cmp_t[a]  = commit ? shadow_t[a] : active_t[a];
            diff_c[a] = $signed({2'b00, iGray}) - $signed({2'b00, cmp_t[a]}) + HALF_S;
            ge_c[a]   = (iGray >= cmp_t[a]);
            rgn_c[a]  = (diff_c[a] >= ZERO_S) && (diff_c[a] < RAMP_S);
            // Only meaningful inside the region, where diff is 0..2H-1.
            off_c[a]  = diff_c[a][RAMP_SH-1:0];
        end
    end

    logic                s1_vld;
    logic                s1_smooth;
    logic signed [15:0]  s1_x;
    logic signed [15:0]  s1_y;
    logic [NT-1:0]       s1_ge;
    logic [NT-1:0]       s1_rgn;
    logic [RAMP_SH-1:0]  s1_off [NT];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_vld    <= 1'b0;
            s1_smooth <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_ge     <= '0;
            s1_rgn    <= '0;
            for (int a = 0; a < NT; a++) begin
                s1_off[a] <= '0;
            end
        end else begin
            s1_vld    <= iValid;
            s1_smooth <= iSmooth;
            s1_x      <= iX_Cont;
            s1_y      <= iY_Cont;
            s1_ge     <= ge_c;
            s1_rgn    <= rgn_c;
            for (int a = 0; a < NT; a++) begin
                s1_off[a] <= off_c[a];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: band count, lowest ramp region, ramp distance
    // ------------------------------------------------------------------
    logic [2:0]         cnt_c;
    logic [2:0]         sel_c;
    logic               has_c;
    logic [RAMP_SH-1:0] dist_c;
    logic               ramp_c;

    always_comb begin
        cnt_c  = '0;
        sel_c  = '0;
        has_c  = 1'b0;
        dist_c = '0;
        for (int a = 0; a < NT; a++) begin
            cnt_c = cnt_c + 3'(s1_ge[a]);
        end
        // Descending scan so the lowest matching region is the last to write.
        for (int a = NT - 1; a >= 0; a--) begin
            if (s1_rgn[a]) begin
                has_c  = 1'b1;
                sel_c  = 3'(a);
                dist_c = s1_off[a];
            end
        end
        ramp_c = s1_smooth && has_c;
    end

    logic                s2_vld;
    logic signed [15:0]  s2_x;
    logic signed [15:0]  s2_y;
    logic [2:0]          s2_band;
    logic [RAMP_SH-1:0]  s2_dist;

    // A zero distance turns the ramp formula into plain L(band), so block
    // pixels and pixels outside every region share the S3 datapath.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s2_vld  <= 1'b0;
            s2_x    <= '0;
            s2_y    <= '0;
            s2_band <= '0;
            s2_dist <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_x    <= s1_x;
            s2_y    <= s1_y;
            s2_band <= ramp_c ? sel_c : cnt_c;
            s2_dist <= ramp_c ? dist_c : '0;
        end
    end

    // ------------------------------------------------------------------
    // S3: L(band) + ((dist * step) >> RAMP_SH), registered
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] lo_c;
    logic [DATA_W-1:0] step_c;
    logic [PW-1:0]     prod_c;
    logic [DATA_W-1:0] pix_c;

    always_comb begin
        lo_c   = '0;
        step_c = '0;
        for (int a = 0; a <= NT; a++) begin
            if (s2_band == 3'(a)) begin
                lo_c = level_of(a);
            end
        end
        for (int a = 0; a < NT; a++) begin
            if (s2_band == 3'(a)) begin
                step_c = level_of(a + 1) - level_of(a);
            end
        end
        prod_c = {{DATA_W{1'b0}}, s2_dist} * {{RAMP_SH{1'b0}}, step_c};
        // dist < 2^RAMP_SH keeps the shifted term below step, so no overflow.
        pix_c  = lo_c + DATA_W'(prod_c >> RAMP_SH);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oValid  <= 1'b0;
            oPixel  <= '0;
            oBand   <= '0;
            oX_Cont <= '0;
            oY_Cont <= '0;
        end else begin
            oValid <= s2_vld;
            if (s2_vld) begin
                oPixel  <= pix_c;
                oBand   <= s2_band;
                oX_Cont <= s2_x;
                oY_Cont <= s2_y;
            end
        end
    end

endmodule

// File: tb/tb_multi_level_thresh.sv
// Directed plus randomized checks of multi_level_thresh against a behavioural model.
// Latency: expected results are queued and compared 3 edges after they are driven.
// Backpressure: none; one stimulus vector per clock.
module tb_multi_level_thresh;

    localparam int W   = 8;
    localparam int NT  = 2;
    localparam int RSH = 3;
    localparam int H   = 4;

    logic               iClk;
    logic               iRst_n;
    logic [W-1:0]       iGray;
    logic               iValid;
    logic signed [15:0] iX_Cont;
    logic signed [15:0] iY_Cont;
    logic               iSmooth;
    logic               iThreshWr;
    logic [2:0]         iThreshAddr;
    logic [W-1:0]       iThreshData;
    logic [W-1:0]       oPixel;
    logic               oValid;
    logic signed [15:0] oX_Cont;
    logic signed [15:0] oY_Cont;
    logic [2:0]         oBand;

    multi_level_thresh #(
        .DATA_W     (W),
        .NUM_THRESH (NT),
        .RAMP_SH    (RSH)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iGray       (iGray),
        .iValid      (iValid),
        .iX_Cont     (iX_Cont),
        .iY_Cont     (iY_Cont),
        .iSmooth     (iSmooth),
        .iThreshWr   (iThreshWr),
        .iThreshAddr (iThreshAddr),
        .iThreshData (iThreshData),
        .oPixel      (oPixel),
        .oValid      (oValid),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oBand       (oBand)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    typedef struct {
        logic               vld;
        logic [W-1:0]       pix;
        logic [2:0]         band;
        logic signed [15:0] x;
        logic signed [15:0] y;
    } exp_t;

    exp_t pipe [$];
    exp_t held;
    int   m_shadow [NT];
    int   m_active [NT];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic int lvl(input int k);
        return (k * ((1 << W) - 1)) / NT;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check("oValid",  oValid,  e.vld);
        check("oPixel",  oPixel,  e.pix);
        check("oBand",   oBand,   e.band);
        check("oX_Cont", oX_Cont, e.x);
        check("oY_Cont", oY_Cont, e.y);
    endtask

    // Reset state of the model: both tables at j*2^W/(NT+1), outputs zero,
    // and two cleared pipeline slots ahead of the first new pixel.
    task automatic model_reset();
        for (int j = 0; j < NT; j++) begin
            m_shadow[j] = ((j + 1) * (1 << W)) / (NT + 1);
            m_active[j] = m_shadow[j];
        end
        held = '{vld: 1'b0, pix: '0, band: '0, x: '0, y: '0};
        pipe.delete();
        pipe.push_back(held);
        pipe.push_back(held);
    endtask

    // Drive one clock worth of inputs, predict the result, then compare the
    // output that belongs to the vector driven three edges ago.
    task automatic cycle(input logic vld, input int g, input int x, input int y, input logic sm,
                         input logic wr, input int addr, input int data);
        exp_t e;
        int   t [NT];
        int   k;
        int   pix;
        int   band;
        logic commit;
        iValid      = vld;
        iGray       = W'(g);
        iX_Cont     = 16'(x);
        iY_Cont     = 16'(y);
        iSmooth     = sm;
        iThreshWr   = wr;
        iThreshAddr = 3'(addr);
        iThreshData = W'(data);

        commit = vld && (x == 0) && (y == 0);
        for (int j = 0; j < NT; j++) t[j] = commit ? m_shadow[j] : m_active[j];

        k = 0;
        for (int j = 0; j < NT; j++) if (t[j] <= g) k++;
        pix  = lvl(k);
        band = k;
        if (sm) begin
            for (int j = 1; j <= NT; j++) begin
                if ((g >= t[j-1] - H) && (g < t[j-1] + H)) begin
                    pix  = lvl(j - 1) + (((g - t[j-1] + H) * (lvl(j) - lvl(j - 1))) >> RSH);
                    band = j - 1;
                    break;
                end
            end
        end

        if (vld) begin
            held.pix  = W'(pix);
            held.band = 3'(band);
            held.x    = 16'(x);
            held.y    = 16'(y);
        end
        e     = held;
        e.vld = vld;
        pipe.push_back(e);

        if (commit) for (int j = 0; j < NT; j++) m_active[j] = m_shadow[j];
        if (wr && (addr < NT)) m_shadow[addr] = data;

        @(posedge iClk);
        #1;
        if (pipe.size() >= 3) check_outputs(pipe.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 9, 9, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int g;
        int x;
        int y;

        iRst_n      = 1'b1;
        iValid      = 1'b0;
        iGray       = '0;
        iX_Cont     = '0;
        iY_Cont     = '0;
        iSmooth     = 1'b0;
        iThreshWr   = 1'b0;
        iThreshAddr = '0;
        iThreshData = '0;
        model_reset();

        // Asynchronous reset, checked before any clock edge.
        #1 iRst_n = 1'b0;
        #1 check_outputs(held);
        @(posedge iClk);
        @(posedge iClk);
        #1 iRst_n = 1'b1;

        // Block mode on thresholds 67 / 111.
        cycle(1'b0, 0, 9, 9, 1'b0, 1'b1, 0, 67);
        cycle(1'b0, 0, 9, 9, 1'b0, 1'b1, 1, 111);
        cycle(1'b1, 66,  0, 0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 67,  1, 0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 110, 2, 0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 111, 3, 0, 1'b0, 1'b0, 0, 0);

        // Smooth mode across both ramps and between them.
        cycle(1'b1, 62,  0, 1, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 63,  1, 1, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 67,  2, 1, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 70,  3, 1, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 71,  4, 1, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 111, 5, 1, 1'b1, 1'b0, 0, 0);

        // Mid-frame write waits for the next frame start.
        cycle(1'b0, 0, 9, 9, 1'b0, 1'b1, 0, 100);
        cycle(1'b1, 90, 5, 5, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 90, 0, 0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 90, 1, 0, 1'b0, 1'b0, 0, 0);

        // Gapped valid, per-pixel mode, write to a nonexistent index.
        cycle(1'b1, 98, 7, 3, 1'b1, 1'b0, 0, 0);
        cycle(1'b0, 98, 0, 0, 1'b1, 1'b1, 5, 0);
        cycle(1'b1, 98, 8, 3, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 105, 9, 3, 1'b1, 1'b0, 0, 0);
        idle(3);

        // Write coinciding with a commit stays in shadow until the next frame.
        cycle(1'b1, 120, 0, 0, 1'b0, 1'b1, 1, 30);
        cycle(1'b1, 50,  1, 0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 50,  0, 0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 50,  1, 0, 1'b1, 1'b0, 0, 0);

        // Randomized traffic with table rewrites and frequent frame starts.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                g = $urandom_range(0, 255);
            end else begin
                g = m_active[$urandom_range(0, NT - 1)] + int'($urandom_range(0, 12)) - 6;
                if (g < 0)   g = 0;
                if (g > 255) g = 255;
            end
            x = int'($urandom_range(0, 7)) - 2;
            y = int'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, g, x, y, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
        end

        // Move the tables away from their reset values, then reset mid-stream.
        cycle(1'b0, 0, 9, 9, 1'b0, 1'b1, 0, 200);
        cycle(1'b0, 0, 9, 9, 1'b0, 1'b1, 1, 200);
        cycle(1'b1, 150, 0, 0, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 151, 1, 0, 1'b1, 1'b0, 0, 0);
        cycle(1'b1, 152, 2, 0, 1'b0, 1'b0, 0, 0);
        iValid    = 1'b0;
        iThreshWr = 1'b0;
        #2 iRst_n = 1'b0;
        model_reset();
        #1 check_outputs(held);
        @(posedge iClk);
        #1 iRst_n = 1'b1;

        cycle(1'b1, 85, 2, 2, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 170, 3, 2, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, 84, 4, 2, 1'b1, 1'b0, 0, 0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
